cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
//  Multi-cycle controller sequencing the direct-mapped, write-back data cache
//  against main memory. Holds tag/valid/dirty state, detects hit/miss, stalls
//  PC and pipeline on a miss, and runs writeback-then-refill over a req/ack
//  handshake to MM. Sits between Ctrl/ALU (MemRead/MemWrite, ALUOut address)
//  and the cache data array / MM pair.
// PARAMETERS
//  ADDR_W   8  byte address width (ALUOut)
//  INDEX_W  3  index bits; 2**INDEX_W lines, one byte per line
//  CNT_W    8  width of hit/miss statistics counters
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  cpu_rd      in   1        load request (MemRead)
//  cpu_wr      in   1        store request (MemWrite)
//  cpu_addr    in   ADDR_W   request byte address
//  stall       out  1        hold PC/IM/REG; request not complete this cycle
//  hit         out  1        request completes this cycle from cache
//  cache_idx   out  INDEX_W  data-array line select (= cpu_addr index bits)
//  cache_we    out  1        write CPU store data into data array
//  cache_fill  out  1        write mm read data into data array
//  mm_rd       out  1        MM read request (refill)
//  mm_wr       out  1        MM write request (writeback of old line)
//  mm_addr     out  ADDR_W   MM address for current mm_rd/mm_wr
//  mm_ack      in   1        MM done; one-cycle pulse, any latency >= 1 cycle
//  hit_cnt     out  CNT_W    first-attempt hits, saturating
//  miss_cnt    out  CNT_W    misses, saturating
// BEHAVIOUR
//  Address split: tag = cpu_addr[ADDR_W-1:INDEX_W], idx = cpu_addr[INDEX_W-1:0].
//  req = cpu_rd | cpu_wr; if both high, treated as store.
//  lookup_hit = valid[idx] & (tag_ram[idx] == tag), combinational.
//  States: IDLE, WB, FILL.
//  IDLE:
//   - no req: stall=0, hit=0; mm_ack ignored.
//   - req & lookup_hit: hit=1, stall=0, zero added latency. Store also sets
//     cache_we=1 and dirty[idx]<=1 at clock edge.
//   - req & miss: stall=1 same cycle; latch cpu_addr into req_addr; miss_cnt++.
//     dirty[idx]&valid[idx] -> WB, else -> FILL.
//  WB: mm_wr=1, mm_addr={tag_ram[idx_q], idx_q}; stall=1; hold until mm_ack,
//      then -> FILL.
//  FILL: mm_rd=1, mm_addr=req_addr; stall=1. On mm_ack: cache_fill=1 that
//      cycle; tag_ram<=tag_q, valid<=1, dirty<=0; set retry flag -> IDLE.
//  Retry: stalled CPU re-presents the request in IDLE; it hits; hit=1,
//      stall=0, store writes/dirties as normal. Retry hit NOT counted in
//      hit_cnt; retry flag clears on any IDLE cycle.
//  mm_rd/mm_wr decoded from registered state (glitch-free), never both high;
//  mm_addr held stable while request high.
//  Miss latency: 1 (miss detect) + MM latency [+ WB MM latency] + 1 (retry).
//  Counters saturate at 2**CNT_W-1; no wrap.
//  cpu_addr/cpu_rd/cpu_wr changes while stall=1 are ignored (req_addr used).
//  Reset (async, any state incl. mid-WB/FILL): state=IDLE, valid[*]=0,
//   dirty[*]=0, counters=0, retry=0; mm_rd=mm_wr=cache_fill=cache_we=0
//   immediately. stall/hit=0 unless a request is present (then a miss).
//  Late mm_ack after reset is ignored in IDLE.
// TESTING
//  1 Reset, load 0x2A -> stall 1 cyc, mm_rd addr 0x2A, ack after 3 cyc,
//    cache_fill pulse, retry hit=1; miss_cnt=1, hit_cnt=0.
//  2 Load 0x2A again -> hit=1, stall=0 same cycle, hit_cnt=1, no mm_rd.
//  3 Store 0x2A (hit) then load 0x4A (same idx 2, tag differs) -> mm_wr
//    addr 0x2A first, then mm_rd addr 0x4A; mm_rd/mm_wr never overlap.
//  4 Load miss to clean line: no mm_wr; cpu_rd&cpu_wr together -> store path.
//  5 Assert rst while in WB waiting for ack -> mm_wr drops asynchronously,
//    counters 0, next access to same addr misses without writeback.
//  6 Drive 300 first-attempt hits -> hit_cnt holds 255.

Source files
------------

// File: rtl/cache_miss_ctrl_if.sv
// Bundle of every signal between the cache miss controller, the CPU/cache side
// and main memory.
//   cpu_rd, cpu_wr, cpu_addr : load/store request from the pipeline
//   stall, hit               : request status back to the pipeline
//   cache_idx, cache_we,
//   cache_fill               : data-array line select and write strobes
//   mm_rd, mm_wr, mm_addr,
//   mm_ack                   : main-memory request/acknowledge
//   hit_cnt, miss_cnt        : saturating statistics
//   state_dbg                : controller state (0 IDLE, 1 WB, 2 FILL)
// The controller binds to the slave modport; the requester/memory side binds
// to the master modport.
interface cache_miss_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 8
);
  logic               cpu_rd;
  logic               cpu_wr;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               stall;
  logic               hit;
  logic [INDEX_W-1:0] cache_idx;
  logic               cache_we;
  logic               cache_fill;
  logic               mm_rd;
  logic               mm_wr;
  logic [ADDR_W-1:0]  mm_addr;
  logic               mm_ack;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;
  logic [1:0]         state_dbg;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, mm_ack,
    output stall, hit, cache_idx, cache_we, cache_fill,
           mm_rd, mm_wr, mm_addr, hit_cnt, miss_cnt, state_dbg
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, mm_ack,
    input  stall, hit, cache_idx, cache_we, cache_fill,
           mm_rd, mm_wr, mm_addr, hit_cnt, miss_cnt, state_dbg
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss controller for a direct-mapped, write-back, one-byte-per-line data
// cache. Keeps tag/valid/dirty per line, resolves hits combinationally, and on
// a miss stalls the pipeline while it writes back a dirty victim (WB) and then
// refills the line from main memory (FILL). The CPU re-presents the stalled
// request after the refill; that retry hits but is not counted as a hit.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : cache_miss_ctrl_if.slave (CPU request, cache strobes, MM handshake,
//          statistics, state_dbg)
// MM handshake: mm_rd/mm_wr stay high with mm_addr stable until mm_ack is
// seen high on a rising edge; mm_ack is a one-cycle pulse and is ignored
// unless a request is outstanding.
module cache_miss_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_miss_ctrl_if.slave bus
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_ram_q [LINES];
  logic [TAG_W-1:0]    tag_ram_d [LINES];
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
  logic                mm_rd_q, mm_rd_d;
  logic                mm_wr_q, mm_wr_d;
  logic                retry_q, retry_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]    cpu_tag, req_tag;
  logic [INDEX_W-1:0]  cpu_idx, req_idx;
  logic                req, lookup_hit;
  logic                stall, hit, cache_we, cache_fill;

  assign cpu_tag    = bus.cpu_addr[ADDR_W-1:INDEX_W];
  assign cpu_idx    = bus.cpu_addr[INDEX_W-1:0];
  assign req_tag    = req_addr_q[ADDR_W-1:INDEX_W];
  assign req_idx    = req_addr_q[INDEX_W-1:0];
  assign req        = bus.cpu_rd | bus.cpu_wr;
  assign lookup_hit = valid_q[cpu_idx] & (tag_ram_q[cpu_idx] == cpu_tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_ram_d  = tag_ram_q;
    req_addr_d = req_addr_q;
    mm_addr_d  = mm_addr_q;
    mm_rd_d    = mm_rd_q;
    mm_wr_d    = mm_wr_q;
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall      = 1'b0;
    hit        = 1'b0;
    cache_we   = 1'b0;
    cache_fill = 1'b0;

    case (state_q)
      IDLE: begin
        // The retry window is exactly the first IDLE cycle after a refill.
        retry_d = 1'b0;
        if (req) begin
          if (lookup_hit) begin
            hit = 1'b1;
            // A simultaneous load+store is handled as a store.
            if (bus.cpu_wr) begin
              cache_we         = 1'b1;
              dirty_d[cpu_idx] = 1'b1;
            end
            if (!retry_q && (hit_cnt_q != '1)) begin
              hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
          end else begin
            stall      = 1'b1;
            req_addr_d = bus.cpu_addr;
            if (miss_cnt_q != '1) begin
              miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
            if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
              state_d   = WB;
              mm_wr_d   = 1'b1;
              mm_addr_d = {tag_ram_q[cpu_idx], cpu_idx};
            end else begin
              state_d   = FILL;
              mm_rd_d   = 1'b1;
              mm_addr_d = bus.cpu_addr;
            end
          end
        end
      end

      WB: begin
        stall = 1'b1;
        if (bus.mm_ack) begin
          // mm_wr falls on the same edge mm_rd rises, so they never overlap.
          state_d   = FILL;
          mm_wr_d   = 1'b0;
          mm_rd_d   = 1'b1;
          mm_addr_d = req_addr_q;
        end
      end

      FILL: begin
        stall = 1'b1;
        if (bus.mm_ack) begin
          cache_fill         = 1'b1;
          tag_ram_d[req_idx] = req_tag;
          valid_d[req_idx]   = 1'b1;
          dirty_d[req_idx]   = 1'b0;
          retry_d            = 1'b1;
          mm_rd_d            = 1'b0;
          state_d            = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        mm_rd_d = 1'b0;
        mm_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_ram_q[i] <= '0;
      end
      req_addr_q <= '0;
      mm_addr_q  <= '0;
      mm_rd_q    <= 1'b0;
      mm_wr_q    <= 1'b0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_ram_q  <= tag_ram_d;
      req_addr_q <= req_addr_d;
      mm_addr_q  <= mm_addr_d;
      mm_rd_q    <= mm_rd_d;
      mm_wr_q    <= mm_wr_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // While stalled the data array is addressed from the latched request, so a
  // wandering cpu_addr cannot misdirect the refill write.
  assign bus.cache_idx  = (state_q == IDLE) ? cpu_idx : req_idx;
  assign bus.stall      = stall;
  assign bus.hit        = hit;
  assign bus.cache_we   = cache_we;
  assign bus.cache_fill = cache_fill;
  assign bus.mm_rd      = mm_rd_q;
  assign bus.mm_wr      = mm_wr_q;
  assign bus.mm_addr    = mm_addr_q;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;
  localparam int ADDR_W  = 8;
  localparam int INDEX_W = 3;
  localparam int CNT_W   = 8;
  localparam int LINES   = 8;

  logic clk;
  logic rst;

  cache_miss_ctrl_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) bus ();

  cache_miss_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Expected MM operations in order: {is_write, address}.
  logic [ADDR_W:0] exp_q[$];

  // Reference cache contents, kept at line level.
  bit         m_valid [LINES];
  bit         m_dirty [LINES];
  logic [4:0] m_tag   [LINES];
  int         m_hit_cnt;
  int         m_miss_cnt;

  // MM responder controls
  int mm_lat_fixed = 0;   // >0: fixed latency in cycles, else random 1..5
  bit mm_hold      = 1'b0;
  bit late_ack_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hit_cnt  = 0;
    m_miss_cnt = 0;
  endtask

  // ---------------- MM responder ----------------
  initial begin
    int  wait_left;
    bit  busy;
    bus.mm_ack = 1'b0;
    busy       = 1'b0;
    wait_left  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        bus.mm_ack = 1'b0;
        busy       = 1'b0;
      end else if (bus.mm_ack) begin
        bus.mm_ack = 1'b0;
        busy       = 1'b0;
      end else if (late_ack_req) begin
        bus.mm_ack   = 1'b1;
        late_ack_req = 1'b0;
      end else if ((bus.mm_rd || bus.mm_wr) && !mm_hold) begin
        if (!busy) begin
          busy      = 1'b1;
          wait_left = (mm_lat_fixed > 0) ? mm_lat_fixed - 1 : int'($urandom_range(0, 4));
        end
        if (wait_left == 0) bus.mm_ack = 1'b1;
        else wait_left--;
      end
    end
  end

  // ---------------- MM bus monitor ----------------
  initial begin
    logic              prev_rd, prev_wr;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W:0]   obs, e;
    prev_rd   = 1'b0;
    prev_wr   = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (bus.mm_rd || bus.mm_wr)
          check("mm_rd_wr_exclusive", 32'(bus.mm_rd & bus.mm_wr), 0);
        if ((bus.mm_rd && !prev_rd) || (bus.mm_wr && !prev_wr)) begin
          obs = {bus.mm_wr, bus.mm_addr};
          check("mm_op_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mm_op", 32'(obs), 32'(e));
          end
        end else if ((bus.mm_rd && prev_rd) || (bus.mm_wr && prev_wr)) begin
          check("mm_addr_stable", 32'(bus.mm_addr), 32'(prev_addr));
        end
        if (bus.mm_ack || bus.cache_fill)
          check("cache_fill", 32'(bus.cache_fill), 32'(bus.mm_ack & bus.mm_rd));
      end
      prev_rd   = bus.mm_rd;
      prev_wr   = bus.mm_wr;
      prev_addr = bus.mm_addr;
    end
  end

  // ---------------- driver ----------------
  // Presents one request and holds it until it completes. lat returns the
  // number of cycles after the first one until stall dropped (0 for a hit).
  task automatic do_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                           output int lat);
    logic [4:0] tag;
    logic [2:0] idx;
    bit         is_hit;
    tag = addr[7:3];
    idx = addr[2:0];
    lat = 0;
    @(negedge clk);
    check("hit_cnt", 32'(bus.hit_cnt), 32'(m_hit_cnt));
    check("miss_cnt", 32'(bus.miss_cnt), 32'(m_miss_cnt));
    bus.cpu_rd   = rd;
    bus.cpu_wr   = wr;
    bus.cpu_addr = addr;
    #1;
    is_hit = m_valid[idx] && (m_tag[idx] == tag);
    check("cache_idx", 32'(bus.cache_idx), 32'(idx));
    if (is_hit) begin
      check("hit", 32'(bus.hit), 1);
      check("hit_stall", 32'(bus.stall), 0);
      check("hit_cache_we", 32'(bus.cache_we), 32'(wr));
      if (wr) m_dirty[idx] = 1'b1;
      if (m_hit_cnt < 255) m_hit_cnt++;
    end else begin
      check("miss_stall", 32'(bus.stall), 1);
      check("miss_hit", 32'(bus.hit), 0);
      if (m_valid[idx] && m_dirty[idx]) exp_q.push_back({1'b1, m_tag[idx], idx});
      exp_q.push_back({1'b0, addr});
      if (m_miss_cnt < 255) m_miss_cnt++;
      do begin
        @(negedge clk);
        #1;
        lat++;
      end while (bus.stall && lat < 100);
      check("miss_completes", 32'(bus.stall), 0);
      check("retry_hit", 32'(bus.hit), 1);
      check("retry_cache_we", 32'(bus.cache_we), 32'(wr));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = wr;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    #1;
    check("idle_stall", 32'(bus.stall), 0);
    check("idle_hit", 32'(bus.hit), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_mm_rd", 32'(bus.mm_rd), 0);
    check("rst_mm_wr", 32'(bus.mm_wr), 0);
    check("rst_hit_cnt", 32'(bus.hit_cnt), 0);
    check("rst_miss_cnt", 32'(bus.miss_cnt), 0);
    check("rst_state", 32'(bus.state_dbg), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: cold load miss with 3-cycle memory
    mm_lat_fixed = 3;
    do_access(1'b1, 1'b0, 8'h2A, lat);
    check("t1_latency", 32'(lat), 4);
    idle_cycle();
    check("t1_miss_cnt", 32'(bus.miss_cnt), 1);
    check("t1_hit_cnt", 32'(bus.hit_cnt), 0);

    // 2: repeat load hits with no memory traffic
    do_access(1'b1, 1'b0, 8'h2A, lat);
    check("t2_latency", 32'(lat), 0);
    idle_cycle();
    check("t2_hit_cnt", 32'(bus.hit_cnt), 1);
    mm_lat_fixed = 0;

    // 3: dirty the line, then conflict miss forces writeback then refill
    do_access(1'b0, 1'b1, 8'h2A, lat);
    do_access(1'b1, 1'b0, 8'h4A, lat);

    // 4: clean-line miss, and load+store together takes the store path
    do_access(1'b1, 1'b0, 8'h6A, lat);
    do_access(1'b1, 1'b1, 8'h13, lat);
    do_access(1'b1, 1'b0, 8'h33, lat);

    // 5: reset while waiting in WB
    do_access(1'b0, 1'b1, 8'h6A, lat);
    mm_hold = 1'b1;
    @(negedge clk);
    check("t5_hit_cnt", 32'(bus.hit_cnt), 32'(m_hit_cnt));
    bus.cpu_rd   = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 8'h2A;
    exp_q.push_back({1'b1, 8'h6A});
    #1;
    check("t5_stall", 32'(bus.stall), 1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.mm_wr && n < 20);
    check("t5_in_wb", 32'(bus.mm_wr), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_mm_wr_async", 32'(bus.mm_wr), 0);
    check("t5_mm_rd_async", 32'(bus.mm_rd), 0);
    check("t5_hit_cnt", 32'(bus.hit_cnt), 0);
    check("t5_miss_cnt", 32'(bus.miss_cnt), 0);
    check("t5_state", 32'(bus.state_dbg), 0);
    check("t5_stall_req_present", 32'(bus.stall), 1);
    model_reset();
    @(negedge clk);
    bus.cpu_rd   = 1'b0;
    rst          = 1'b0;
    mm_hold      = 1'b0;
    late_ack_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t5_late_ack_state", 32'(bus.state_dbg), 0);
    check("t5_late_ack_mm_rd", 32'(bus.mm_rd), 0);
    check("t5_late_ack_mm_wr", 32'(bus.mm_wr), 0);
    check("t5_queue_drained", 32'(exp_q.size()), 0);
    do_access(1'b1, 1'b0, 8'h2A, lat);

    // random mix
    for (int i = 0; i < 250; i++) begin
      logic [ADDR_W-1:0] a;
      int sel;
      a   = ADDR_W'(($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) idle_cycle();
      do_access(sel != 1, sel != 0, a, lat);
    end

    // 6: hit counter saturates
    do_access(1'b1, 1'b0, 8'h55, lat);
    for (int i = 0; i < 300; i++) do_access(1'b1, 1'b0, 8'h55, lat);
    idle_cycle();
    check("t6_hit_cnt_sat", 32'(bus.hit_cnt), 255);
    check("t6_model_sat", 32'(bus.hit_cnt), 32'(m_hit_cnt));
    check("final_queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
